// File: rtl/spiflash_host.sv
// SPI mode-0 initiator for single-byte flash transactions: 32-bit address,
// 8-bit command and one data byte per frame, driven from a valid/ready port.
module spiflash_host #(
  parameter int CLKDIV = 1,
  parameter int CSGAP  = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAdr,
  input  logic [7:0]  ReqWData,
  output logic        RespValid,
  output logic [7:0]  RespRData,
  output logic        SCLK,
  output logic        CS,
  output logic        MOSI,
  input  logic        MISO
);

  generate
    if (CLKDIV < 1 || CSGAP < 1) begin : g_bad_param
      $error("spiflash_host: CLKDIV and CSGAP must both be >= 1");
    end
  endgenerate

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GW = (CSGAP > 2) ? $clog2(CSGAP - 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((CSGAP > 1) ? CSGAP - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [5:0]    edge_q, edge_d;
  logic [48:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          wr_q, wr_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          div_done;

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    gap_d        = gap_q;
    edge_d       = edge_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    wr_d         = wr_q;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    mosi_d       = mosi_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        if (ReqValid && ready_q) begin
          state_d = S_SETUP;
          ready_d = 1'b0;
          cs_d    = 1'b0;
          wr_d    = ReqWrite;
          // tx[48] is always the bit currently on MOSI; trailing 0 is the commit edge
          tx_d    = {ReqAdr, (ReqWrite ? 8'h02 : 8'h01),
                     (ReqWrite ? ReqWData : 8'h00), 1'b0};
          mosi_d  = ReqAdr[31];
          div_d   = '0;
          edge_d  = '0;
        end
      end
      S_SETUP: begin
        if (div_done) begin
          div_d   = '0;
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          edge_d  = 6'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_done) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[47:0], 1'b0};
            mosi_d = tx_q[47];
            if (edge_q >= 6'd41 && edge_q <= 6'd48) begin
              rx_d = {rx_q[6:0], MISO};
            end
          end else if (edge_q == 6'd49) begin
            // the low phase after the last falling edge belongs to SHIFT
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end else begin
            sclk_d = 1'b1;
            edge_d = edge_q + 6'd1;
          end
        end
      end
      S_HOLD: begin
        mosi_d = 1'b0;
        if (div_done) begin
          div_d        = '0;
          state_d      = S_DONE;
          cs_d         = 1'b1;
          resp_valid_d = 1'b1;
          rdata_d      = wr_q ? 8'h00 : rx_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        if (CSGAP == 1) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      gap_q        <= '0;
      edge_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      wr_q         <= 1'b0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      edge_q       <= edge_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      wr_q         <= wr_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ReqReady  = ready_q;
  assign RespValid = resp_valid_q;
  assign RespRData = rdata_q;
  assign SCLK      = sclk_q;
  assign CS        = cs_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spiflash_host.sv
// Self-checking bench for spiflash_host: a behavioural SPI flash device plus a
// reference memory predict every response; timing is checked in PCLK edges.
module tb_spiflash_host;

  logic        pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        presetn;
  logic        req_valid, req_valid2, req_write;
  logic [31:0] req_adr;
  logic [7:0]  req_wdata;
  logic        req_ready, resp_valid, sclk, cs, mosi, miso;
  logic [7:0]  resp_rdata;
  logic        req_ready2, resp_valid2, sclk2, cs2, mosi2;
  logic [7:0]  resp_rdata2;

  spiflash_host #(.CLKDIV(1), .CSGAP(3)) u_dut (
    .PCLK(pclk), .PRESETn(presetn), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWrite(req_write), .ReqAdr(req_adr), .ReqWData(req_wdata),
    .RespValid(resp_valid), .RespRData(resp_rdata),
    .SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso)
  );

  spiflash_host #(.CLKDIV(3), .CSGAP(1)) u_dut3 (
    .PCLK(pclk), .PRESETn(presetn), .ReqValid(req_valid2), .ReqReady(req_ready2),
    .ReqWrite(req_write), .ReqAdr(req_adr), .ReqWData(req_wdata),
    .RespValid(resp_valid2), .RespRData(resp_rdata2),
    .SCLK(sclk2), .CS(cs2), .MOSI(mosi2), .MISO(1'b1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge pclk) cyc++;

  // Flash device model: collects the frame bit-serially, answers reads, commits writes.
  logic [7:0]  dev_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  int          fcnt = 0;
  int          f_frames = 0;
  int          f_mosi_bad = 0;
  logic [39:0] fbits;
  logic [31:0] f_adr;
  logic [7:0]  f_cmd, f_data, f_wbits;

  initial miso = 1'b0;

  always @(negedge cs) begin
    fcnt = 0; fbits = '0; f_wbits = '0; f_mosi_bad = 0;
  end

  always @(posedge sclk) begin
    if (cs === 1'b0) begin
      fcnt++;
      if (fcnt <= 40) fbits = {fbits[38:0], mosi};
      if (fcnt == 40) begin
        f_adr  = fbits[39:8];
        f_cmd  = fbits[7:0];
        f_data = dev_mem.exists(f_adr) ? dev_mem[f_adr] : 8'h00;
      end
      if (fcnt >= 41 && fcnt <= 48) begin
        f_wbits = {f_wbits[6:0], mosi};
        if (f_cmd == 8'h01) begin
          miso = f_data[3'(48 - fcnt)];
          if (mosi !== 1'b0) f_mosi_bad++;
        end else begin
          miso = 1'b0;
        end
      end
      if (fcnt == 49) begin
        if (mosi !== 1'b0) f_mosi_bad++;
        if (f_cmd == 8'h02) dev_mem[f_adr] = f_wbits;
        f_frames++;
      end
    end
  end

  // CS framing monitor for u_dut; edge numbers refer to the PCLK edge that samples the value.
  int   cs_fall_e = 0, cs_rise_e = 0, cs_low_len = 0, cs_high_len = 0, resp_cnt = 0;
  logic prev_cs = 1'b1;
  always @(negedge pclk) begin
    if (prev_cs === 1'b1 && cs === 1'b0) begin
      cs_fall_e   = cyc + 1;
      cs_high_len = cyc + 1 - cs_rise_e;
    end
    if (prev_cs === 1'b0 && cs === 1'b1) begin
      cs_rise_e  = cyc + 1;
      cs_low_len = cyc + 1 - cs_fall_e;
    end
    if (resp_valid === 1'b1) resp_cnt++;
    prev_cs = cs;
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic start_req(input bit w, input logic [31:0] a, input logic [7:0] d,
                           output int hs_e);
    int n = 0;
    req_write = w; req_adr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge pclk);
    while (req_ready !== 1'b1 && n < 400) begin
      @(negedge pclk);
      n++;
    end
    hs_e = cyc + 1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL handshake_timeout: ReqReady=%b required 1", req_ready);
    else n_pass++;
    @(posedge pclk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [7:0] rd, output int rv_e);
    int n = 0;
    @(negedge pclk);
    while (resp_valid !== 1'b1 && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    rd   = resp_rdata;
    rv_e = cyc + 1;
    n_checks++;
    if (resp_valid !== 1'b1) $display("FAIL resp_timeout: RespValid=%b required 1", resp_valid);
    else n_pass++;
    @(posedge pclk); #2;
  endtask

  task automatic do_xact(input bit w, input logic [31:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int hs_e, output int rv_e);
    start_req(w, a, d, hs_e);
    wait_resp(rd, rv_e);
  endtask

  task automatic test_reset;
    presetn = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_adr = '0; req_wdata = '0;
    #1 presetn = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++; if (cs !== 1'b1)      $display("FAIL reset_cs: got %b want 1", cs);           else n_pass++;
    n_checks++; if (sclk !== 1'b0)    $display("FAIL reset_sclk: got %b want 0", sclk);       else n_pass++;
    n_checks++; if (mosi !== 1'b0)    $display("FAIL reset_mosi: got %b want 0", mosi);       else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", resp_rdata); else n_pass++;
    n_checks++; if (cs2 !== 1'b1)     $display("FAIL reset_cs2: got %b want 1", cs2);         else n_pass++;
    @(posedge pclk); #2 presetn = 1'b1;
    @(negedge pclk);
    n_checks++; if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", req_ready); else n_pass++;
    @(negedge pclk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", req_ready); else n_pass++;
    @(posedge pclk); #2;
  endtask

  task automatic test_read_basic;
    logic [7:0] rd;
    int hs, rv, n;
    preload(32'h0000_0010, 8'hA5);
    do_xact(1'b0, 32'h0000_0010, 8'h5A, rd, hs, rv);
    n_checks++; if (rd !== 8'hA5)       $display("FAIL read_data: got %h want a5", rd);           else n_pass++;
    n_checks++; if (rv - hs != 101)     $display("FAIL read_latency: got %0d want 101", rv - hs); else n_pass++;
    n_checks++; if (f_adr !== 32'h10)   $display("FAIL read_adr: got %h want 00000010", f_adr);   else n_pass++;
    n_checks++; if (f_cmd !== 8'h01)    $display("FAIL read_cmd: got %h want 01", f_cmd);         else n_pass++;
    n_checks++; if (cs_low_len != 100)  $display("FAIL cs_low: got %0d want 100", cs_low_len);    else n_pass++;
    n_checks++; if (f_mosi_bad != 0)    $display("FAIL read_mosi_zero: got %0d bad bits want 0", f_mosi_bad); else n_pass++;
    n = 0;
    @(negedge pclk);
    while (req_ready !== 1'b1 && n < 50) begin @(negedge pclk); n++; end
    n_checks++;
    if ((cyc + 1) - hs != 104) $display("FAIL ready_return: got %0d want 104", (cyc + 1) - hs);
    else n_pass++;
    @(posedge pclk); #2;
  endtask

  task automatic test_write_read;
    logic [31:0] a;
    logic [7:0]  d, rd;
    int hs, rv;
    a = $urandom;
    d = 8'($urandom_range(1, 255));
    do_xact(1'b1, a, d, rd, hs, rv);
    n_checks++; if (rd !== 8'h00)  $display("FAIL write_rdata: got %h want 00", rd);  else n_pass++;
    n_checks++; if (f_cmd !== 8'h02) $display("FAIL write_cmd: got %h want 02", f_cmd); else n_pass++;
    n_checks++; if (f_adr !== a)   $display("FAIL write_adr: got %h want %h", f_adr, a); else n_pass++;
    ref_mem[a] = d;
    do_xact(1'b0, a, 8'h00, rd, hs, rv);
    n_checks++; if (rd !== ref_rd(a)) $display("FAIL readback: got %h want %h", rd, ref_rd(a)); else n_pass++;
    n_checks++; if (f_cmd !== 8'h01)  $display("FAIL readback_cmd: got %h want 01", f_cmd);      else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [7:0]  d, rd, exp;
    bit          w;
    int hs, rv;
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_1000 + $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      exp = w ? 8'h00 : ref_rd(a);
      if (w) ref_mem[a] = d;
      do_xact(w, a, d, rd, hs, rv);
      n_checks++; if (rd !== exp) $display("FAIL rand_rdata[%0d]: got %h want %h", i, rd, exp); else n_pass++;
      n_checks++; if (f_adr !== a) $display("FAIL rand_adr[%0d]: got %h want %h", i, f_adr, a); else n_pass++;
      n_checks++;
      if (f_cmd !== (w ? 8'h02 : 8'h01)) $display("FAIL rand_cmd[%0d]: got %h want %h", i, f_cmd, w ? 8'h02 : 8'h01);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd1, rd2;
    int hs1, hs2, rv1, rv2, n, frames0;
    preload(32'h1, 8'($urandom));
    preload(32'h2, 8'($urandom));
    frames0 = f_frames;
    req_write = 1'b0; req_adr = 32'h1; req_valid = 1'b1;
    n = 0;
    @(negedge pclk);
    while (req_ready !== 1'b1 && n < 400) begin @(negedge pclk); n++; end
    hs1 = cyc + 1;
    @(posedge pclk); #2 req_adr = 32'h2;
    n = 0;
    @(negedge pclk);
    while (resp_valid !== 1'b1 && n < 400) begin @(negedge pclk); n++; end
    rd1 = resp_rdata; rv1 = cyc + 1;
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin @(negedge pclk); n++; end
    hs2 = cyc + 1;
    @(posedge pclk); #2 req_valid = 1'b0;
    wait_resp(rd2, rv2);
    n_checks++; if (hs2 - hs1 != 104) $display("FAIL b2b_spacing: got %0d want 104", hs2 - hs1); else n_pass++;
    n_checks++; if (rv1 - hs1 != 101) $display("FAIL b2b_latency: got %0d want 101", rv1 - hs1); else n_pass++;
    n_checks++; if (cs_high_len < 3)  $display("FAIL b2b_cs_gap: got %0d want >=3", cs_high_len); else n_pass++;
    n_checks++; if (rd1 !== ref_rd(32'h1)) $display("FAIL b2b_rd1: got %h want %h", rd1, ref_rd(32'h1)); else n_pass++;
    n_checks++; if (rd2 !== ref_rd(32'h2)) $display("FAIL b2b_rd2: got %h want %h", rd2, ref_rd(32'h2)); else n_pass++;
    n_checks++; if (f_frames - frames0 != 2) $display("FAIL b2b_frames: got %0d want 2", f_frames - frames0); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    logic [31:0] a;
    logic [7:0]  rd;
    int hs, rv, n, ready_seen;
    a = 32'h0002_0000 | 32'($urandom_range(0, 255));
    preload(a, 8'($urandom));
    req_write = 1'b0; req_adr = a; req_valid = 1'b1;
    n = 0;
    @(negedge pclk);
    while (req_ready !== 1'b1 && n < 400) begin @(negedge pclk); n++; end
    hs = cyc + 1;
    ready_seen = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge pclk); #2;
      req_valid = 1'($urandom); req_adr = $urandom; req_write = 1'($urandom);
      @(negedge pclk);
      if (req_ready === 1'b1) ready_seen++;
    end
    @(posedge pclk); #2 req_valid = 1'b0;
    wait_resp(rd, rv);
    n_checks++; if (ready_seen != 0) $display("FAIL busy_ready: got %0d ready cycles want 0", ready_seen); else n_pass++;
    n_checks++; if (f_adr !== a)     $display("FAIL busy_adr: got %h want %h", f_adr, a);            else n_pass++;
    n_checks++; if (f_cmd !== 8'h01) $display("FAIL busy_cmd: got %h want 01", f_cmd);               else n_pass++;
    n_checks++; if (rd !== ref_rd(a)) $display("FAIL busy_rdata: got %h want %h", rd, ref_rd(a));    else n_pass++;
    n_checks++; if (rv - hs != 101)  $display("FAIL busy_latency: got %0d want 101", rv - hs);       else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [31:0] a;
    logic [7:0]  rd;
    int hs, rv, n, resp0, frames0;
    a = 32'h0003_0040;
    preload(a, 8'h96);
    start_req(1'b0, a, 8'h00, hs);
    n = 0;
    while (fcnt < 20 && n < 200) begin @(negedge pclk); n++; end
    n_checks++; if (fcnt != 20) $display("FAIL midframe_reach: got edge %0d want 20", fcnt); else n_pass++;
    resp0 = resp_cnt; frames0 = f_frames;
    presetn = 1'b0;
    #1;
    n_checks++; if (cs !== 1'b1)   $display("FAIL midreset_cs: got %b want 1", cs);     else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL midreset_sclk: got %b want 0", sclk); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL midreset_rvalid: got %b want 0", resp_valid); else n_pass++;
    repeat (2) @(posedge pclk);
    #2 presetn = 1'b1;
    repeat (150) @(negedge pclk);
    n_checks++; if (resp_cnt != resp0) $display("FAIL midreset_no_resp: got %0d pulses want 0", resp_cnt - resp0); else n_pass++;
    n_checks++; if (f_frames != frames0) $display("FAIL midreset_no_frame: got %0d frames want 0", f_frames - frames0); else n_pass++;
    @(posedge pclk); #2;
    do_xact(1'b0, a, 8'h00, rd, hs, rv);
    n_checks++; if (rd !== 8'h96) $display("FAIL post_reset_read: got %h want 96", rd); else n_pass++;
    n_checks++; if (rv - hs != 101) $display("FAIL post_reset_latency: got %0d want 101", rv - hs); else n_pass++;
  endtask

  task automatic test_clkdiv3;
    bit   q[$];
    int   hs, rv, n, low_cnt, rises, bad_runs, run, last_run;
    logic [7:0] rd;
    req_write = 1'b0; req_adr = $urandom; req_valid2 = 1'b1;
    n = 0;
    @(negedge pclk);
    while (req_ready2 !== 1'b1 && n < 400) begin @(negedge pclk); n++; end
    hs = cyc + 1;
    @(posedge pclk); #2 req_valid2 = 1'b0;
    n = 0;
    @(negedge pclk);
    while (resp_valid2 !== 1'b1 && n < 1000) begin
      if (cs2 === 1'b0) q.push_back(sclk2);
      @(negedge pclk);
      n++;
    end
    rd = resp_rdata2; rv = cyc + 1;
    low_cnt = q.size();
    rises = 0; bad_runs = 0; run = 1; last_run = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] != q[i-1]) begin
        if (run != 3) bad_runs++;
        if (q[i] == 1'b1) rises++;
        run = 1;
      end else begin
        run++;
      end
    end
    last_run = run;
    n_checks++; if (resp_valid2 !== 1'b1) $display("FAIL div3_resp: got %b want 1", resp_valid2); else n_pass++;
    n_checks++; if (low_cnt != 300) $display("FAIL div3_cs_low: got %0d want 300", low_cnt);      else n_pass++;
    n_checks++; if (rises != 49)    $display("FAIL div3_rises: got %0d want 49", rises);          else n_pass++;
    n_checks++; if (bad_runs != 0)  $display("FAIL div3_phase: got %0d bad phases want 0", bad_runs); else n_pass++;
    n_checks++; if (last_run != 6)  $display("FAIL div3_tail: got %0d want 6", last_run);         else n_pass++;
    n_checks++; if (rv - hs != 301) $display("FAIL div3_latency: got %0d want 301", rv - hs);     else n_pass++;
    n_checks++; if (rd !== 8'hFF)   $display("FAIL div3_rdata: got %h want ff", rd);              else n_pass++;
    @(posedge pclk); #2;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_clkdiv3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
